// File: rtl/counter_pkg.sv
// Shared types for the modulo-N counter: count modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } count_mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/modn_step.sv
// Modulo-N step logic: from the current value and direction, produce the
// value one step away (with wrap-around) and flag when that step crosses
// the counting boundary. Explicit compares are used for every MOD,
// including powers of two, so natural overflow is never relied upon.
module modn_step #(
  parameter int MOD   = 7,
  parameter int WIDTH = $clog2(MOD)
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_terminal,
  output logic             o_wrap_cond
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic w_at_max;
  logic w_at_zero;

  assign w_at_max  = (i_value == MAX_V);
  assign w_at_zero = (i_value == '0);

  // Next value in the requested direction, folding back at either end
  always_comb begin
    o_next = i_value;
    if (i_up) begin
      o_next = w_at_max ? '0 : i_value + WIDTH'(1);
    end else begin
      o_next = w_at_zero ? MAX_V : i_value - WIDTH'(1);
    end
  end

  assign o_terminal  = i_up ? w_at_max : w_at_zero;
  // A step taken while terminal is exactly a boundary crossing
  assign o_wrap_cond = o_terminal;

endmodule

// File: rtl/counter_modn.sv
// Modulo-MOD up/down counter with wrap, saturate and one-shot modes,
// synchronous load (clamped to MOD-1) and a RUN/HALT control FSM.
module counter_modn
  import counter_pkg::*;
#(
  parameter int MOD   = 7,
  parameter int WIDTH = $clog2(MOD)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_value,
  output logic             o_terminal,
  output logic             o_wrap,
  output logic             o_halted
);

  if (MOD < 2 || MOD > 65536) begin : g_bad_mod
    $error("counter_modn: MOD must be in 2..65536");
  end
  if ((64'd1 << WIDTH) < 64'(MOD)) begin : g_bad_width
    $error("counter_modn: WIDTH too small to hold MOD-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  // Loaded values beyond the counting range are pinned to the top value
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] lv);
    return (lv > MAX_V) ? MAX_V : lv;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_step_next;
  logic             w_terminal;
  logic             w_wrap_cond;
  logic             w_step_req;

  modn_step #(
    .MOD   (MOD),
    .WIDTH (WIDTH)
  ) u_step (
    .i_value     (r_value),
    .i_up        (i_up),
    .o_next      (w_step_next),
    .o_terminal  (w_terminal),
    .o_wrap_cond (w_wrap_cond)
  );

  // A step is only taken while running and when no load overrides it
  assign w_step_req = i_enable && (r_state == RUN) && !i_load;

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: one-shot halts at the boundary, load always resumes
  always_comb begin
    w_state_nxt = r_state;
    if (i_load) begin
      w_state_nxt = RUN;
    end else if (w_step_req && w_terminal && (count_mode_t'(i_mode) == ONESHOT)) begin
      w_state_nxt = HALT;
    end
  end

  // FSM outputs
  always_comb begin
    o_halted = (r_state == HALT);
  end

  // Next count and wrap pulse; reserved mode 3 falls into the wrap branch
  always_comb begin
    w_value_nxt = r_value;
    w_wrap_nxt  = 1'b0;
    if (i_load) begin
      w_value_nxt = clamp_load(i_load_value);
    end else if (w_step_req) begin
      if (!w_terminal) begin
        w_value_nxt = w_step_next;
      end else begin
        case (count_mode_t'(i_mode))
          SAT:     w_value_nxt = r_value;
          ONESHOT: w_value_nxt = r_value;
          default: begin
            w_value_nxt = w_step_next;
            w_wrap_nxt  = w_wrap_cond;
          end
        endcase
      end
    end
  end

  // Count and wrap registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign o_value    = r_value;
  assign o_wrap     = r_wrap;
  assign o_terminal = w_terminal;

endmodule

// File: tb/tb_counter_modn.sv
// Scoreboard bench for counter_modn: three instances (MOD=7, 8, 2) share
// one stimulus stream; a modular-arithmetic reference model predicts each
// cycle's outputs and a separate monitor compares them on the falling edge.
module tb_counter_modn;

  typedef struct packed {
    logic [31:0] v;
    logic        w;
    logic        h;
    logic        t;
  } exp_t;

  localparam int NDUT = 3;
  localparam int MODS [NDUT] = '{7, 8, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic [1:0] mode;
  logic       ld;
  logic [2:0] lv;

  logic [2:0] v0, v1;
  logic [0:0] v2;
  logic       t0, t1, t2, w0, w1, w2, h0, h1, h2;

  logic [31:0] act_v [NDUT];
  logic        act_t [NDUT];
  logic        act_w [NDUT];
  logic        act_h [NDUT];

  exp_t q [NDUT][$];

  int mv [NDUT];
  bit mw [NDUT];
  bit mh [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_modn #(.MOD(7), .WIDTH(3)) u_dut7 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_mode(mode),
    .i_load(ld), .i_load_value(lv), .o_value(v0), .o_terminal(t0),
    .o_wrap(w0), .o_halted(h0)
  );

  counter_modn #(.MOD(8), .WIDTH(3)) u_dut8 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_mode(mode),
    .i_load(ld), .i_load_value(lv), .o_value(v1), .o_terminal(t1),
    .o_wrap(w1), .o_halted(h1)
  );

  counter_modn #(.MOD(2), .WIDTH(1)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_mode(mode),
    .i_load(ld), .i_load_value(lv[0:0]), .o_value(v2), .o_terminal(t2),
    .o_wrap(w2), .o_halted(h2)
  );

  assign act_v[0] = 32'(v0);
  assign act_v[1] = 32'(v1);
  assign act_v[2] = 32'(v2);
  assign act_t[0] = t0;
  assign act_t[1] = t1;
  assign act_t[2] = t2;
  assign act_w[0] = w0;
  assign act_w[1] = w1;
  assign act_w[2] = w2;
  assign act_h[0] = h0;
  assign act_h[1] = h1;
  assign act_h[2] = h2;

  // Reference model: counting is arithmetic mod m; a boundary crossing is
  // detected by the stepped value moving the "wrong" way.
  task automatic model_update(input int d, input bit r, input bit l, input bit e,
                              input bit u, input bit [1:0] md, input int lval);
    int m;
    int nv;
    bit crossed;
    m = MODS[d];
    if (r) begin
      mv[d] = 0; mh[d] = 0; mw[d] = 0;
    end else if (l) begin
      mv[d] = (lval < m) ? lval : m - 1;
      mh[d] = 0; mw[d] = 0;
    end else begin
      mw[d] = 0;
      if (e && !mh[d]) begin
        nv = (mv[d] + (u ? 1 : m - 1)) % m;
        crossed = u ? (nv < mv[d]) : (nv > mv[d]);
        if (!crossed) mv[d] = nv;
        else if (md == 2'd1) mv[d] = mv[d];
        else if (md == 2'd2) mh[d] = 1;
        else begin
          mv[d] = nv;
          mw[d] = 1;
        end
      end
    end
  endtask

  // Drive one cycle: queue the outputs expected with these inputs applied,
  // then advance the model across the coming rising edge.
  task automatic step(input bit r, input bit l, input bit e, input bit u,
                      input bit [1:0] md, input bit [2:0] lvi);
    exp_t ex;
    int   lval;
    rst = r; ld = l; en = e; up = u; mode = md; lv = lvi;
    for (int d = 0; d < NDUT; d++) begin
      ex.v = 32'(mv[d]);
      ex.w = mw[d];
      ex.h = mh[d];
      ex.t = u ? (mv[d] == MODS[d] - 1) : (mv[d] == 0);
      q[d].push_back(ex);
      lval = (d == 2) ? int'(lvi[0]) : int'(lvi);
      model_update(d, r, l, e, u, md, lval);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input int d, input string nm, input logic [31:0] act,
                        input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL dut%0d %s: got %0d expected %0d at %0t", d, nm, act, req, $time);
    end
  endtask

  // Monitor: every cycle presents a fresh output set for each instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          check1(d, "value",    act_v[d],         e.v);
          check1(d, "terminal", 32'(act_t[d]),    32'(e.t));
          check1(d, "wrap",     32'(act_w[d]),    32'(e.w));
          check1(d, "halted",   32'(act_h[d]),    32'(e.h));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d expected completion", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; up = 1'b1; mode = 2'd0; lv = 3'd0;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) model_update(d, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0);

    // Wrap up through the boundary
    step(1, 0, 0, 1, 2'd0, 3'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 2'd0, 3'd0);
    // Wrap down from zero
    step(1, 0, 0, 0, 2'd0, 3'd0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 2'd0, 3'd0);
    // Saturate at the top
    step(0, 1, 0, 1, 2'd1, 3'd5);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 2'd1, 3'd0);
    // Saturate at the bottom
    step(0, 1, 0, 0, 2'd1, 3'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 2'd1, 3'd0);
    // One-shot halts, ignores direction/mode while halted, load resumes
    step(0, 1, 0, 1, 2'd2, 3'd4);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 2'd2, 3'd0);
    step(0, 0, 1, 0, 2'd0, 3'd0);
    step(0, 0, 1, 1, 2'd3, 3'd0);
    step(0, 1, 1, 1, 2'd2, 3'd2);
    step(0, 0, 1, 1, 2'd2, 3'd0);
    // Load clamp, load beats enable, reset beats load
    step(0, 1, 0, 1, 2'd0, 3'd7);
    step(0, 0, 0, 1, 2'd0, 3'd0);
    step(0, 1, 1, 1, 2'd0, 3'd3);
    step(0, 1, 1, 1, 2'd0, 3'd3);
    step(1, 1, 1, 1, 2'd0, 3'd5);
    // Halt then reset clears it
    step(0, 1, 0, 1, 2'd2, 3'd6);
    step(0, 0, 1, 1, 2'd2, 3'd0);
    step(1, 0, 1, 1, 2'd2, 3'd0);
    // Reserved mode behaves as wrap, both directions
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1, 2'd3, 3'd0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 2'd3, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 75),
           1'($urandom),
           2'($urandom),
           3'($urandom));
    end

    step(0, 0, 0, 1, 2'd0, 3'd0);
    step(0, 0, 0, 1, 2'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (q[d].size() != 0) begin
        bad++;
        $display("FAIL dut%0d drain: %0d entries left, expected 0", d, q[d].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
